arbitro_soma_sinal: RTL and testbench
=====================================

Name: arbitro_soma_sinal

Overview:
- Sequencing controller and two-port arbiter around the shared mixed-sign 8-bit adder datapath.
- Two requesters (A, B) submit operand sets plus a 2-bit `codigo` over valid/ready.
- The block grants one requester round-robin, captures its operands, computes the sum in a registered stage, and returns it with the requester ID over a valid/ready output.
- Sits between the command sources and any result consumer, so one adder serves both.

Parameters:
- PRIORIDADE_INICIAL, 0, requester favoured on the first arbitration after reset (0 = A, 1 = B).

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous reset, active-high
- a_valid  input  1  requester A has a command
- a_ready  output  1  A command accepted this cycle
- a_signed_1  input  8  A signed operand 1
- a_signed_2  input  4  A signed operand 2
- a_unsigned_1  input  8  A unsigned operand 1
- a_unsigned_2  input  4  A unsigned operand 2
- a_codigo  input  2  A operation select
- b_valid, b_ready, b_signed_1, b_signed_2, b_unsigned_1, b_unsigned_2, b_codigo: same as A, for requester B
- saida_valid  output  1  result available
- saida_ready  input  1  consumer accepts result
- saida  output  8  result
- saida_origem  output  1  0 = result for A, 1 = result for B

Behaviour:
- Reset: state OCIOSO; saida_valid=0; saida=0; saida_origem=0; a_ready=b_ready=0; round-robin pointer = PRIORIDADE_INICIAL. Reset wins over every other event, including mid-CALCULA or mid-ENTREGA: the in-flight command is dropped with no output.
- States: OCIOSO -> CALCULA -> ENTREGA -> OCIOSO.
- OCIOSO: grant is combinational. If exactly one valid is high, that requester is granted. If both are high, the pointer's requester is granted. The granted *_ready is high in the same cycle; the other *_ready stays 0. The handshake (valid && ready) captures codigo, the four operands and the origin, moves to CALCULA, and sets the pointer to the other requester. With no valid, stay in OCIOSO with both ready=0.
- *_ready is 0 in every state except OCIOSO.
- CALCULA: one cycle; result registered into saida/saida_origem; next state ENTREGA.
- ENTREGA: saida_valid=1. saida and saida_origem are held stable while saida_ready=0. On saida_ready=1: saida_valid goes to 0 next cycle and state returns to OCIOSO.
- Latency: handshake in cycle N gives saida_valid in cycle N+2. Peak throughput is one command per 3 cycles.
- Arithmetic (8-bit result, wraps modulo 256):
  - codigo 0: sext(signed_1) + sext(signed_2 to 8 bits)
  - codigo 1: unsigned_1 + zext(unsigned_2)
  - codigo 2: unsigned_1 + signed_1, raw bit patterns
  - codigo 3: unsigned_1 + zext(signed_2); the 4-bit pattern is zero-extended, not sign-extended (unsigned expression context)
- Operand inputs are don't-care outside the handshake cycle.

Optional Feature:
- OVERFLOW_FLAG_EN defined: adds output port saida_overflow (1 bit).
  - Registered in CALCULA alongside saida, held through ENTREGA, reset 0.
  - codigo 0: 1 when the signed 8-bit result differs from the true 9-bit signed sum.
  - codigo 1-3: 1 when the 9-bit unsigned sum has a carry out of bit 7.
- Not defined: port and logic absent; all other behaviour identical.

Test Plan:
- A only, codigo=0, signed_1=0xF0 (-16), signed_2=0xF (-1) -> saida_valid at handshake+2, saida=0xEF, origem=0; with OVERFLOW_FLAG_EN, overflow=0.
- A, codigo=0, signed_1=0x7F, signed_2=0x1 -> saida=0x80; overflow=1. Then codigo=1, unsigned_1=0xFF, unsigned_2=0x1 -> saida=0x00, overflow=1.
- B, codigo=3, unsigned_1=0x10, signed_2=0xF -> saida=0x1F (zero-extension), never 0x0F; codigo=2, unsigned_1=0x05, signed_1=0xFE -> saida=0x03.
- After reset with PRIORIDADE_INICIAL=0, A and B held valid continuously -> grants alternate A,B,A,B; saida_origem sequence 0,1,0,1; losing requester's ready=0.
- saida_ready held 0 for 5 cycles in ENTREGA -> saida, saida_origem and saida_valid stable; a_ready=b_ready=0 throughout; accepted on the cycle saida_ready=1.
- rst asserted during ENTREGA -> next cycle saida_valid=0, saida=0, state OCIOSO, pointer = PRIORIDADE_INICIAL; the dropped result never appears.

Source files
------------

// File: rtl/arbitro_soma_sinal.sv
// arbitro_soma_sinal: round-robin arbiter and sequencer for the shared
// mixed-sign 8-bit adder. Two requesters (A, B) hand over an operand set and a
// 2-bit codigo. One is granted, its operands are captured, the sum is
// registered, and the result is returned with the requester ID.
//
// Optional feature: define OVERFLOW_FLAG_EN to add the saida_overflow output.
//
// Handshake rules, applied identically on both command ports and on the result
// port: a transfer happens on a rising edge where valid && ready are both high.
// A producer holds valid and its payload until that edge. The ready of a
// command port is combinational from the valid inputs and is high only in
// OCIOSO for the granted requester. The result is held stable while
// saida_valid && !saida_ready.
//
// The estado and ponteiro outputs expose the FSM state and the round-robin
// pointer so that checkers can observe them directly.

module arbitro_soma_sinal #(
   parameter logic PRIORIDADE_INICIAL = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   // requester A
   input  logic       a_valid,
   output logic       a_ready,
   input  logic [7:0] a_signed_1,
   input  logic [3:0] a_signed_2,
   input  logic [7:0] a_unsigned_1,
   input  logic [3:0] a_unsigned_2,
   input  logic [1:0] a_codigo,
   // requester B
   input  logic       b_valid,
   output logic       b_ready,
   input  logic [7:0] b_signed_1,
   input  logic [3:0] b_signed_2,
   input  logic [7:0] b_unsigned_1,
   input  logic [3:0] b_unsigned_2,
   input  logic [1:0] b_codigo,
   // result
   output logic       saida_valid,
   input  logic       saida_ready,
   output logic [7:0] saida,
   // observation of internal state
   output logic [1:0] estado,
   output logic       ponteiro,
   output logic       saida_origem
`ifdef OVERFLOW_FLAG_EN
   ,
   output logic       saida_overflow
`endif
);

   // The adder works one bit wider only when the carry/overflow is reported.
`ifdef OVERFLOW_FLAG_EN
   localparam int LW = 9;
`else
   localparam int LW = 8;
`endif

   typedef enum logic [1:0] {
      OCIOSO  = 2'd0,
      CALCULA = 2'd1,
      ENTREGA = 2'd2
   } estado_t;

   estado_t estado_q;
   estado_t estado_d;

   logic ptr_q;

   // Captured command.
   logic [1:0] cod_q;
   logic [7:0] s1_q;
   logic [3:0] s2_q;
   logic [7:0] u1_q;
   logic [3:0] u2_q;
   logic       orig_q;

   // Arbitration.
   logic grant_a;
   logic grant_b;
   logic aceita;

   // Datapath.
   logic [LW-1:0] op_x;
   logic [LW-1:0] op_y;
   logic [LW-1:0] soma;

   // Combinational grant. With one valid, that one wins. With two valids,
   // the pointer decides.
   always_comb begin
      grant_a = a_valid && (!b_valid || (ptr_q == 1'b0));
      grant_b = b_valid && (!a_valid || (ptr_q == 1'b1));
   end

   // A command is accepted only in OCIOSO and never while reset is held.
   assign aceita = (estado_q == OCIOSO) && !rst && (grant_a || grant_b);

   // State register.
   always_ff @(posedge clk) begin
      if (rst) estado_q <= OCIOSO;
      else     estado_q <= estado_d;
   end

   // Next-state logic: OCIOSO -> CALCULA -> ENTREGA -> OCIOSO.
   always_comb begin
      estado_d = estado_q;
      case (estado_q)
         OCIOSO:  if (aceita) estado_d = CALCULA;
         CALCULA: estado_d = ENTREGA;
         ENTREGA: if (saida_ready) estado_d = OCIOSO;
         default: estado_d = OCIOSO;
      endcase
   end

   // Output logic: ready only in OCIOSO for the granted side, valid in ENTREGA.
   always_comb begin
      a_ready     = 1'b0;
      b_ready     = 1'b0;
      saida_valid = 1'b0;
      case (estado_q)
         OCIOSO: begin
            a_ready = grant_a && !rst;
            b_ready = grant_b && !rst;
         end
         ENTREGA: saida_valid = 1'b1;
         default: ;
      endcase
   end

   // Round-robin pointer: after a grant, the other requester is favoured.
   always_ff @(posedge clk) begin
      if (rst)         ptr_q <= PRIORIDADE_INICIAL;
      else if (aceita) ptr_q <= !grant_b;
   end

   // Capture the winning command on its handshake.
   always_ff @(posedge clk) begin
      if (rst) begin
         cod_q  <= '0;
         s1_q   <= '0;
         s2_q   <= '0;
         u1_q   <= '0;
         u2_q   <= '0;
         orig_q <= 1'b0;
      end else if (aceita) begin
         if (grant_b) begin
            cod_q <= b_codigo;
            s1_q  <= b_signed_1;
            s2_q  <= b_signed_2;
            u1_q  <= b_unsigned_1;
            u2_q  <= b_unsigned_2;
         end else begin
            cod_q <= a_codigo;
            s1_q  <= a_signed_1;
            s2_q  <= a_signed_2;
            u1_q  <= a_unsigned_1;
            u2_q  <= a_unsigned_2;
         end
         orig_q <= grant_b;
      end
   end

   // Operand selection. Only codigo 0 sign-extends. In codigo 3 the 4-bit
   // signed field is treated as an unsigned pattern and zero-extended.
   always_comb begin
      op_x = '0;
      op_y = '0;
      case (cod_q)
         2'd0: begin
            op_x = LW'($signed(s1_q));
            op_y = LW'($signed(s2_q));
         end
         2'd1: begin
            op_x = LW'(u1_q);
            op_y = LW'(u2_q);
         end
         2'd2: begin
            op_x = LW'(u1_q);
            op_y = LW'(s1_q);
         end
         default: begin
            op_x = LW'(u1_q);
            op_y = LW'(s2_q);
         end
      endcase
      soma = op_x + op_y;
   end

   // Result register: loaded in CALCULA, held through ENTREGA and afterwards.
   always_ff @(posedge clk) begin
      if (rst) begin
         saida        <= '0;
         saida_origem <= 1'b0;
      end else if (estado_q == CALCULA) begin
         saida        <= soma[7:0];
         saida_origem <= orig_q;
      end
   end

`ifdef OVERFLOW_FLAG_EN
   // Overflow flag: signed overflow for codigo 0, carry out of bit 7 otherwise.
   always_ff @(posedge clk) begin
      if (rst) begin
         saida_overflow <= 1'b0;
      end else if (estado_q == CALCULA) begin
         if (cod_q == 2'd0) saida_overflow <= soma[8] ^ soma[7];
         else               saida_overflow <= soma[8];
      end
   end
`endif

   assign estado   = estado_q;
   assign ponteiro = ptr_q;

endmodule

// File: tb/tb_arbitro_soma_sinal.sv
// Directed bench for arbitro_soma_sinal: a table of single-requester commands
// with hand-computed results, then sequences for arbitration, a held result
// and a reset that lands in ENTREGA.

module tb_arbitro_soma_sinal;

   logic       clk;
   logic       rst;
   logic       a_valid, b_valid;
   logic       a_ready, b_ready;
   logic [7:0] a_signed_1, b_signed_1;
   logic [3:0] a_signed_2, b_signed_2;
   logic [7:0] a_unsigned_1, b_unsigned_1;
   logic [3:0] a_unsigned_2, b_unsigned_2;
   logic [1:0] a_codigo, b_codigo;
   logic       saida_valid;
   logic       saida_ready;
   logic [7:0] saida;
   logic [1:0] estado;
   logic       ponteiro;
   logic       saida_origem;
`ifdef OVERFLOW_FLAG_EN
   logic       saida_overflow;
`endif

   int n_vec = 0;
   int n_err = 0;

   arbitro_soma_sinal #(.PRIORIDADE_INICIAL(1'b0)) dut (
      .clk          (clk),
      .rst          (rst),
      .a_valid      (a_valid),
      .a_ready      (a_ready),
      .a_signed_1   (a_signed_1),
      .a_signed_2   (a_signed_2),
      .a_unsigned_1 (a_unsigned_1),
      .a_unsigned_2 (a_unsigned_2),
      .a_codigo     (a_codigo),
      .b_valid      (b_valid),
      .b_ready      (b_ready),
      .b_signed_1   (b_signed_1),
      .b_signed_2   (b_signed_2),
      .b_unsigned_1 (b_unsigned_1),
      .b_unsigned_2 (b_unsigned_2),
      .b_codigo     (b_codigo),
      .saida_valid  (saida_valid),
      .saida_ready  (saida_ready),
      .saida        (saida),
      .estado       (estado),
      .ponteiro     (ponteiro),
      .saida_origem (saida_origem)
`ifdef OVERFLOW_FLAG_EN
      ,
      .saida_overflow (saida_overflow)
`endif
   );

   // Clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       req;
      logic [1:0] cod;
      logic [7:0] s1;
      logic [3:0] s2;
      logic [7:0] u1;
      logic [3:0] u2;
      logic [7:0] exp_saida;
      logic       exp_ovf;
   } vec_t;

   vec_t tab[10];

   task automatic check(input string nome, input logic [7:0] act, input logic [7:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", nome, act, exp, $time);
      end
   endtask

   // Called just after a negedge. Presents the command, waits for its grant,
   // and returns at the negedge of the CALCULA cycle with valid dropped.
   task automatic issue(input logic req, input logic [1:0] cod, input logic [7:0] s1,
                        input logic [3:0] s2, input logic [7:0] u1, input logic [3:0] u2);
      logic got;
      if (req) begin
         b_codigo = cod; b_signed_1 = s1; b_signed_2 = s2;
         b_unsigned_1 = u1; b_unsigned_2 = u2; b_valid = 1'b1;
      end else begin
         a_codigo = cod; a_signed_1 = s1; a_signed_2 = s2;
         a_unsigned_1 = u1; a_unsigned_2 = u2; a_valid = 1'b1;
      end
      got = 1'b0;
      for (int i = 0; i < 8 && !got; i++) begin
         #1;
         if (req ? b_ready : a_ready) got = 1'b1;
         else @(negedge clk);
      end
      check("grant_seen", {7'd0, got}, 8'd1);
      @(posedge clk);
      @(negedge clk);
      a_valid = 1'b0;
      b_valid = 1'b0;
   endtask

   // Called at the CALCULA negedge. Checks latency, payload, optional stall,
   // and the drop of saida_valid after acceptance.
   task automatic collect(input logic req, input logic [7:0] exp, input logic ovf, input int stall);
      check("valid_in_calcula", {7'd0, saida_valid}, 8'd0);
      @(negedge clk);
      for (int i = 0; i <= stall; i++) begin
         check("valid_entrega", {7'd0, saida_valid}, 8'd1);
         check("saida", saida, exp);
         check("origem", {7'd0, saida_origem}, {7'd0, req});
`ifdef OVERFLOW_FLAG_EN
         check("overflow", {7'd0, saida_overflow}, {7'd0, ovf});
`else
         if (ovf === 1'bx) $display("note: undefined overflow expectation");
`endif
         if (stall > 0) begin
            check("a_ready_stall", {7'd0, a_ready}, 8'd0);
            check("b_ready_stall", {7'd0, b_ready}, 8'd0);
         end
         if (i < stall) @(negedge clk);
      end
      saida_ready = 1'b1;
      @(negedge clk);
      saida_ready = 1'b0;
      check("valid_after_accept", {7'd0, saida_valid}, 8'd0);
      check("estado_ocioso", {6'd0, estado}, 8'd0);
   endtask

   initial begin
      // Table: don't-care fields carry junk so a wrong field selection shows.
      tab[0] = '{1'b0, 2'd0, 8'hF0, 4'hF, 8'hAA, 4'h5, 8'hEF, 1'b0};
      tab[1] = '{1'b0, 2'd0, 8'h7F, 4'h1, 8'h33, 4'h9, 8'h80, 1'b1};
      tab[2] = '{1'b0, 2'd1, 8'h44, 4'h6, 8'hFF, 4'h1, 8'h00, 1'b1};
      tab[3] = '{1'b1, 2'd3, 8'h55, 4'hF, 8'h10, 4'h2, 8'h1F, 1'b0};
      tab[4] = '{1'b1, 2'd2, 8'hFE, 4'h7, 8'h05, 4'hC, 8'h03, 1'b1};
      tab[5] = '{1'b1, 2'd0, 8'h80, 4'h8, 8'h01, 4'h1, 8'h78, 1'b1};
      tab[6] = '{1'b0, 2'd1, 8'h99, 4'hE, 8'h12, 4'h3, 8'h15, 1'b0};
      tab[7] = '{1'b0, 2'd3, 8'h01, 4'h8, 8'hF8, 4'hF, 8'h00, 1'b1};
      tab[8] = '{1'b1, 2'd2, 8'h3F, 4'h9, 8'h40, 4'h6, 8'h7F, 1'b0};
      tab[9] = '{1'b0, 2'd0, 8'h05, 4'h7, 8'hC0, 4'hA, 8'h0C, 1'b0};

      rst = 1'b1;
      a_valid = 1'b0; b_valid = 1'b0; saida_ready = 1'b0;
      a_signed_1 = '0; a_signed_2 = '0; a_unsigned_1 = '0; a_unsigned_2 = '0; a_codigo = '0;
      b_signed_1 = '0; b_signed_2 = '0; b_unsigned_1 = '0; b_unsigned_2 = '0; b_codigo = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // Reset state.
      check("rst_valid", {7'd0, saida_valid}, 8'd0);
      check("rst_saida", saida, 8'h00);
      check("rst_origem", {7'd0, saida_origem}, 8'd0);
      check("rst_estado", {6'd0, estado}, 8'd0);
      check("rst_ponteiro", {7'd0, ponteiro}, 8'd0);
      check("rst_ready", {6'd0, a_ready, b_ready}, 8'd0);
      @(negedge clk);
      check("idle_ready", {6'd0, a_ready, b_ready}, 8'd0);

      // Table of single-requester commands.
      for (int k = 0; k < 10; k++) begin
         issue(tab[k].req, tab[k].cod, tab[k].s1, tab[k].s2, tab[k].u1, tab[k].u2);
         collect(tab[k].req, tab[k].exp_saida, tab[k].exp_ovf, 0);
      end

      // Both requesters held valid after a reset: grants alternate A,B,A,B.
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      a_codigo = 2'd1; a_unsigned_1 = 8'h10; a_unsigned_2 = 4'h1;
      b_codigo = 2'd1; b_unsigned_1 = 8'h20; b_unsigned_2 = 4'h2;
      a_valid = 1'b1; b_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         logic org;
         org = k[0];
         #1;
         check("rr_a_ready", {7'd0, a_ready}, {7'd0, !org});
         check("rr_b_ready", {7'd0, b_ready}, {7'd0, org});
         @(negedge clk);
         check("rr_ready_calcula", {6'd0, a_ready, b_ready}, 8'd0);
         @(negedge clk);
         check("rr_ready_entrega", {6'd0, a_ready, b_ready}, 8'd0);
         check("rr_valid", {7'd0, saida_valid}, 8'd1);
         check("rr_origem", {7'd0, saida_origem}, {7'd0, org});
         check("rr_saida", saida, org ? 8'h22 : 8'h11);
         saida_ready = 1'b1;
         @(negedge clk);
         saida_ready = 1'b0;
      end
      a_valid = 1'b0; b_valid = 1'b0;
      @(negedge clk);

      // Result held for 5 cycles with both requesters pushing.
      issue(1'b0, 2'd1, 8'h00, 4'h0, 8'h33, 4'h4);
      a_valid = 1'b1; b_valid = 1'b1;
      collect(1'b0, 8'h37, 1'b0, 5);
      a_valid = 1'b0; b_valid = 1'b0;
      check("ptr_after_a", {7'd0, ponteiro}, 8'd1);

      // Reset during ENTREGA drops the result and restores the pointer.
      issue(1'b0, 2'd1, 8'h00, 4'h0, 8'h01, 4'h1);
      @(negedge clk);
      check("pre_rst_valid", {7'd0, saida_valid}, 8'd1);
      check("pre_rst_saida", saida, 8'h02);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrst_valid", {7'd0, saida_valid}, 8'd0);
      check("midrst_saida", saida, 8'h00);
      check("midrst_estado", {6'd0, estado}, 8'd0);
      check("midrst_ponteiro", {7'd0, ponteiro}, 8'd0);
      saida_ready = 1'b1;
      repeat (4) begin
         @(negedge clk);
         check("dropped_stays_gone", {7'd0, saida_valid}, 8'd0);
      end
      saida_ready = 1'b0;
      a_valid = 1'b1; b_valid = 1'b1;
      #1;
      check("post_rst_grant_a", {6'd0, a_ready, b_ready}, 8'd2);
      a_valid = 1'b0; b_valid = 1'b0;
      @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   // Global time limit.
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

endmodule
